accum_proc_multi: RTL and testbench

Parametrised bus-master accumulator, successor to the two-operand accumulator processor. It fetches NUM_OPS operands of WIDTH bits from shared memory over the arbitrated req/grant bus and sums them with overflow detection. It then writes the sum back to memory, counts completed jobs and starts again. It sits alongside the other bus masters on the shared op/read/write bus, behind the arbiter.

---
 rtl/accum_proc_multi.sv | 208 ++++++++++++++++++++
 tb/tb_accum_proc_multi.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_proc_multi.sv
// -----------------------------------------------------------------------------
// accum_proc_multi
//
// Bus-master accumulator. Each job fetches NUM_OPS operands of WIDTH bits from
// shared memory through the arbitrated req/grant bus, sums them (unsigned, with
// a sticky overflow flag), writes the sum back, bumps a job counter and starts
// over.
//
// Parameters
//   WIDTH    data / accumulator width (>= 2)
//   NUM_OPS  operands summed per job (>= 1)
//   JOBS_W   width of the completed-job counter (wraps)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   grant      arbiter grant, looked at in REQF / REQS only
//   signal     memory transaction-complete strobe, looked at in RECV / SEND only
//   read       memory read data
//   op         bus opcode (01 FETCH, 10 SEND), high-Z while idle (NOP)
//   write      bus write data, carries the sum in SEND, high-Z otherwise
//   req        bus request to the arbiter
//   state      one-hot state (REQF, RECV, ACC, REQS, SEND)
//   idx        index of the operand being fetched
//   ovf        sticky overflow flag for the current job
//   jobs_done  completed-job counter
//
// Build option
//   ACCUM_SATURATE_EN  when defined, a carry out clamps the sum to all-ones;
//                      otherwise the sum wraps. Both builds set ovf.
// -----------------------------------------------------------------------------
module accum_proc_multi #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 2,
  parameter int JOBS_W  = 16,
  localparam int IDX_W  = $clog2(NUM_OPS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grant,
  input  logic              signal,
  input  logic [WIDTH-1:0]  read,
  output logic [1:0]        op,
  output logic [WIDTH-1:0]  write,
  output logic              req,
  output logic [4:0]        state,
  output logic [IDX_W-1:0]  idx,
  output logic              ovf,
  output logic [JOBS_W-1:0] jobs_done
);

  typedef enum logic [4:0] {
    S_REQF = 5'b00001,
    S_RECV = 5'b00010,
    S_ACC  = 5'b00100,
    S_REQS = 5'b01000,
    S_SEND = 5'b10000
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_SEND  = 2'b10;

`ifdef ACCUM_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Overflow policy for the running sum: clamp to all-ones or wrap.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] raw,
                                               input logic             carry);
    if (SAT_EN && carry) begin
      return {WIDTH{1'b1}};
    end
    return raw;
  endfunction

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [1:0]          op_q, op_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ovf_q, ovf_d;
  logic [JOBS_W-1:0]   jobs_q, jobs_d;

  logic [WIDTH:0]      add_wide;
  logic [WIDTH-1:0]    add_raw;
  logic                add_carry;
  logic                last_op;

  // One extra bit on the adder exposes the carry out of bit WIDTH-1.
  assign add_wide  = {1'b0, sum_q} + {1'b0, opnd_q};
  assign add_raw   = add_wide[WIDTH-1:0];
  assign add_carry = add_wide[WIDTH];
  assign last_op   = (idx_q == IDX_W'(NUM_OPS - 1));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    jobs_d  = jobs_q;

    case (state_q)
      S_REQF: begin
        req_d = 1'b1;
        if (grant) begin
          op_d    = OP_FETCH;
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        // FETCH is only presented for the single cycle after the grant.
        op_d   = OP_NOP;
        // Keep tracking read so the captured operand is the one at the
        // completing edge.
        opnd_d = read;
        if (signal) begin
          req_d   = 1'b0;
          state_d = S_ACC;
        end
      end

      S_ACC: begin
        if (idx_q == '0) begin
          // First operand of a job starts a fresh sum and clears ovf.
          sum_d = opnd_q;
          ovf_d = 1'b0;
        end else begin
          sum_d = sat_add(add_raw, add_carry);
          if (add_carry) begin
            ovf_d = 1'b1;
          end
        end
        if (last_op) begin
          idx_d   = '0;
          state_d = S_REQS;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_REQF;
        end
      end

      S_REQS: begin
        req_d = 1'b1;
        if (grant) begin
          op_d    = OP_SEND;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        op_d = OP_NOP;
        if (signal) begin
          req_d   = 1'b0;
          jobs_d  = jobs_q + JOBS_W'(1);
          state_d = S_REQF;
        end
      end

      default: begin
        state_d = S_REQF;
        req_d   = 1'b0;
        op_d    = OP_NOP;
        idx_d   = '0;
      end
    endcase
  end

  // State register: everything clears asynchronously so the bus is released
  // the moment reset asserts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQF;
      req_q   <= 1'b0;
      op_q    <= OP_NOP;
      opnd_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      jobs_q  <= jobs_d;
    end
  end

  assign op        = (op_q == OP_NOP) ? 2'bzz : op_q;
  assign write     = (state_q == S_SEND) ? sum_q : {WIDTH{1'bz}};
  assign req       = req_q;
  assign state     = state_q;
  assign idx       = idx_q;
  assign ovf       = ovf_q;
  assign jobs_done = jobs_q;

endmodule

// File: tb/tb_accum_proc_multi.sv
module tb_accum_proc_multi;

  logic clk;
  logic reset;

  // u0: WIDTH=32, NUM_OPS=2, JOBS_W=16
  logic        grant0, signal0;
  logic [31:0] read0;
  wire  [1:0]  op0;
  wire  [31:0] write0;
  logic        req0;
  logic [4:0]  state0;
  logic [1:0]  idx0;
  logic        ovf0;
  logic [15:0] jobs0;

  // u1: WIDTH=8, NUM_OPS=3, JOBS_W=16
  logic        grant1, signal1;
  logic [7:0]  read1;
  wire  [1:0]  op1;
  wire  [7:0]  write1;
  logic        req1;
  logic [4:0]  state1;
  logic [1:0]  idx1;
  logic        ovf1;
  logic [15:0] jobs1;

  // u2: WIDTH=8, NUM_OPS=1, JOBS_W=2
  logic        grant2, signal2;
  logic [7:0]  read2;
  wire  [1:0]  op2;
  wire  [7:0]  write2;
  logic        req2;
  logic [4:0]  state2;
  logic [0:0]  idx2;
  logic        ovf2;
  logic [1:0]  jobs2;

  int n_checks;
  int n_fail;

  accum_proc_multi #(.WIDTH(32), .NUM_OPS(2), .JOBS_W(16)) u0 (
    .clk(clk), .reset(reset), .grant(grant0), .signal(signal0), .read(read0),
    .op(op0), .write(write0), .req(req0), .state(state0), .idx(idx0),
    .ovf(ovf0), .jobs_done(jobs0));

  accum_proc_multi #(.WIDTH(8), .NUM_OPS(3), .JOBS_W(16)) u1 (
    .clk(clk), .reset(reset), .grant(grant1), .signal(signal1), .read(read1),
    .op(op1), .write(write1), .req(req1), .state(state1), .idx(idx1),
    .ovf(ovf1), .jobs_done(jobs1));

  accum_proc_multi #(.WIDTH(8), .NUM_OPS(1), .JOBS_W(2)) u2 (
    .clk(clk), .reset(reset), .grant(grant2), .signal(signal2), .read(read2),
    .op(op2), .write(write2), .req(req2), .state(state2), .idx(idx2),
    .ovf(ovf2), .jobs_done(jobs2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] wrap_exp;
  logic [7:0] op_val;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    grant0 = 0; signal0 = 0; read0 = '0;
    grant1 = 0; signal1 = 0; read1 = '0;
    grant2 = 0; signal2 = 0; read2 = '0;
`ifdef ACCUM_SATURATE_EN
    wrap_exp = 8'd255;
`else
    wrap_exp = 8'd54;
`endif
    #2;
    // Reset state
    chk("rst_state", 64'(state0), 64'h01);
    chk("rst_req", 64'(req0), 64'd0);
    n_checks++;
    assert (op0 === 2'bzz) else begin
      n_fail++; $error("FAIL rst_op_z: observed %b expected zz", op0);
    end
    n_checks++;
    assert (write0 === 32'bz) else begin
      n_fail++; $error("FAIL rst_write_z: observed %h expected z", write0);
    end
    chk("rst_jobs", 64'(jobs0), 64'd0);
    chk("rst_idx", 64'(idx0), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);

    // Basic job, immediate handshakes: 5 + 7
    grant0 = 1; signal0 = 1; read0 = 32'd5;
    reset = 1'b0;
    step();
    chk("b1_state", 64'(state0), 64'h02);
    chk("b1_req", 64'(req0), 64'd1);
    chk("b1_op_fetch", 64'(op0), 64'd1);
    step();
    chk("b2_state", 64'(state0), 64'h04);
    chk("b2_req", 64'(req0), 64'd0);
    n_checks++;
    assert (op0 === 2'bzz) else begin
      n_fail++; $error("FAIL b2_op_z: observed %b expected zz", op0);
    end
    read0 = 32'd7;
    step();
    chk("b3_state", 64'(state0), 64'h01);
    chk("b3_idx", 64'(idx0), 64'd1);
    step();
    step();
    step();
    chk("b6_state", 64'(state0), 64'h08);
    chk("b6_idx", 64'(idx0), 64'd0);
    n_checks++;
    assert (write0 === 32'bz) else begin
      n_fail++; $error("FAIL b6_write_z: observed %h expected z", write0);
    end
    step();
    chk("b7_state", 64'(state0), 64'h10);
    chk("b7_write", 64'(write0), 64'd12);
    chk("b7_op_send", 64'(op0), 64'd2);
    chk("b7_req", 64'(req0), 64'd1);
    step();
    chk("b8_state", 64'(state0), 64'h01);
    chk("b8_jobs", 64'(jobs0), 64'd1);
    chk("b8_req", 64'(req0), 64'd0);
    n_checks++;
    assert (write0 === 32'bz) else begin
      n_fail++; $error("FAIL b8_write_z: observed %h expected z", write0);
    end

    // Spurious signal in REQF
    grant0 = 0; signal0 = 1;
    step();
    chk("ign_sig_state", 64'(state0), 64'h01);
    chk("ign_sig_req", 64'(req0), 64'd1);
    // grant and signal together in REQF
    grant0 = 1; signal0 = 1;
    step();
    chk("both_state", 64'(state0), 64'h02);
    chk("both_op", 64'(op0), 64'd1);

    // Delayed signal with read changing every cycle
    grant0 = 0; signal0 = 0; read0 = 32'd100;
    step();
    chk("d1_state", 64'(state0), 64'h02);
    chk("d1_req", 64'(req0), 64'd1);
    n_checks++;
    assert (op0 === 2'bzz) else begin
      n_fail++; $error("FAIL d1_op_z: observed %b expected zz", op0);
    end
    read0 = 32'd101;
    step();
    chk("d2_state", 64'(state0), 64'h02);
    read0 = 32'd102; signal0 = 1;
    step();
    chk("d3_state", 64'(state0), 64'h04);
    chk("d3_req", 64'(req0), 64'd0);
    // Spurious grant in ACC
    grant0 = 1; signal0 = 0; read0 = 32'd7;
    step();
    chk("ign_gnt_acc", 64'(state0), 64'h01);
    chk("d4_idx", 64'(idx0), 64'd1);
    // Delayed grant: 4 cycles with no grant
    grant0 = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dg_state", 64'(state0), 64'h01);
      chk("dg_req", 64'(req0), 64'd1);
    end
    grant0 = 1;
    step();
    chk("dg_recv", 64'(state0), 64'h02);
    grant0 = 0; read0 = 32'd40;
    step();
    read0 = 32'd50; signal0 = 1;
    step();
    chk("d5_state", 64'(state0), 64'h04);
    signal0 = 0;
    step();
    chk("d6_state", 64'(state0), 64'h08);
    chk("d6_ovf", 64'(ovf0), 64'd0);
    grant0 = 1;
    step();
    chk("d7_write", 64'(write0), 64'd152);
    chk("d7_op", 64'(op0), 64'd2);
    // Spurious grant in SEND, no signal yet
    step();
    chk("ign_gnt_send", 64'(state0), 64'h10);
    chk("d8_write", 64'(write0), 64'd152);
    n_checks++;
    assert (op0 === 2'bzz) else begin
      n_fail++; $error("FAIL d8_op_z: observed %b expected zz", op0);
    end
    grant0 = 0; signal0 = 1;
    step();
    chk("d9_jobs", 64'(jobs0), 64'd2);
    chk("d9_state", 64'(state0), 64'h01);

    // Overflowing job, aborted by reset during SEND
    grant0 = 1; signal0 = 1; read0 = 32'hFFFF_FFFF;
    step();
    step();
    read0 = 32'd2;
    for (int i = 0; i < 5; i++) step();
    chk("r_state", 64'(state0), 64'h10);
    chk("r_write", 64'(write0), 64'd1);
    chk("r_ovf", 64'(ovf0), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ra_req", 64'(req0), 64'd0);
    chk("ra_state", 64'(state0), 64'h01);
    chk("ra_jobs", 64'(jobs0), 64'd0);
    chk("ra_ovf", 64'(ovf0), 64'd0);
    n_checks++;
    assert (op0 === 2'bzz) else begin
      n_fail++; $error("FAIL ra_op_z: observed %b expected zz", op0);
    end
    n_checks++;
    assert (write0 === 32'bz) else begin
      n_fail++; $error("FAIL ra_write_z: observed %h expected z", write0);
    end
    step();
    #2;
    read0 = 32'd9;
    reset = 1'b0;
    step();
    step();
    read0 = 32'd4;
    for (int i = 0; i < 5; i++) step();
    chk("rr_state", 64'(state0), 64'h10);
    chk("rr_write", 64'(write0), 64'd13);
    chk("rr_ovf", 64'(ovf0), 64'd0);
    step();
    chk("rr_jobs", 64'(jobs0), 64'd1);
    grant0 = 0; signal0 = 0;

    // Wrap / saturate: 8-bit, 200 + 100 + 10
    grant1 = 1; signal1 = 1; read1 = 8'd200;
    step();
    step();
    read1 = 8'd100;
    step();
    step();
    step();
    read1 = 8'd10;
    step();
    chk("w_idx", 64'(idx1), 64'd2);
    chk("w_ovf_mid", 64'(ovf1), 64'd1);
    step();
    step();
    step();
    chk("w_reqs", 64'(state1), 64'h08);
    step();
    chk("w_write", 64'(write1), 64'(wrap_exp));
    chk("w_ovf", 64'(ovf1), 64'd1);
    step();
    chk("w_jobs", 64'(jobs1), 64'd1);
    grant1 = 0; signal1 = 0;

    // NUM_OPS=1, JOBS_W=2: five jobs, counter wraps to 1
    grant2 = 1; signal2 = 1;
    for (int j = 0; j < 5; j++) begin
      op_val = 8'(17 * j + 3);
      read2 = op_val;
      step();
      step();
      step();
      step();
      chk("n1_write", 64'(write2), 64'(op_val));
      chk("n1_ovf", 64'(ovf2), 64'd0);
      step();
    end
    chk("n1_jobs_wrap", 64'(jobs2), 64'd1);
    grant2 = 0; signal2 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
